div_sequencer: RTL
==================

Name: div_sequencer

Overview:
Multi-cycle issue/response stage that sits directly upstream of the combinational 64-bit signed divider and consumes its quotient and remainder outputs. Requests arrive on a valid/ready interface and are buffered in a small FIFO. The stage applies each operand pair to the divider, holds it stable for DIV_LAT cycles (the divider is a multicycle path), then captures the selected result. Divide-by-zero and signed overflow are resolved locally without using the divider, so the divider's own ovf flag is never relied on for these cases.

Parameters:
DEPTH, 4, request FIFO entries; must be a power of 2 and at least 2
DIV_LAT, 2, cycles that divider operands are held before the result is sampled; must be at least 1
TAG_W, 4, width of the request/response tag

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept; equals !full
req_op  in  1  0 = quotient, 1 = remainder
req_a  in  64  signed dividend
req_b  in  64  signed divisor
req_tag  in  TAG_W  returned unchanged with the response
div_a  out  64  registered dividend to divider
div_b  out  64  registered divisor to divider
div_quo  in  64  divider quotient
div_r  in  64  divider remainder
div_ovf  in  1  divider overflow; not used for special-case detection
rsp_valid  out  1  response held until accepted
rsp_ready  in  1  consumer accepts
rsp_data  out  64  selected result
rsp_tag  out  TAG_W  tag of the response
rsp_dz  out  1  divide-by-zero occurred
rsp_ovf  out  1  signed overflow (INT_MIN / -1)

Behaviour:
- Reset values: all outputs are 0 except req_ready, which is 1. FIFO is empty, FSM is in IDLE, counter is 0.
- Reset mid-operation: queued and in-flight requests are dropped silently. No response is produced for them.
- FIFO:
  - Push occurs on req_valid && req_ready.
  - req_ready depends only on registered full. When full, no push is accepted, even if a pop happens in the same cycle.
  - Pointers are log2(DEPTH)+1 bits with a wrap bit.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Division semantics: signed, truncating toward zero; the remainder takes the sign of the dividend.
- FSM states: IDLE, WAIT, DONE.
- IDLE with FIFO non-empty: pop the head entry, register div_a/div_b and the op/tag.
  - If b == 0: result = quotient 0xFFFF_FFFF_FFFF_FFFF or remainder a; dz = 1; go to DONE.
  - Else if a == 0x8000_0000_0000_0000 and b == all ones: result = quotient 0x8000_0000_0000_0000 or remainder 0; ovf = 1; go to DONE.
  - Otherwise: cnt = DIV_LAT-1; go to WAIT.
- WAIT:
  - div_a and div_b are held constant.
  - If cnt != 0: decrement cnt.
  - If cnt == 0: capture div_quo or div_r per op, with dz = ovf = 0; go to DONE.
- DONE:
  - rsp_valid = 1. rsp_data, rsp_tag, rsp_dz and rsp_ovf are held stable until the handshake.
  - On rsp_valid && rsp_ready with the FIFO non-empty: pop the next entry in the same edge, applying the IDLE rules (back-to-back issue).
  - On rsp_valid && rsp_ready with the FIFO empty: go to IDLE and drop rsp_valid.
- Latency (request into an empty FIFO in IDLE, accepted at edge E0):
  - Special case: rsp_valid high after E1.
  - Normal case: rsp_valid high after E(1+DIV_LAT).
- Ordering: responses are returned strictly in request order.
- div_a/div_b keep their last values when the FSM is idle.

Decomposition:
- Shared package holds:
  - op encoding: OP_QUO = 0, OP_REM = 1
  - FSM state enum: IDLE, WAIT, DONE
  - constants INT64_MIN = 0x8000_0000_0000_0000 and ALL_ONES64
- One sub-module, div_req_fifo: a parameterised DEPTH x (1+64+64+TAG_W) synchronous FIFO with asynchronous active-low reset, full/empty outputs, and push/pop inputs.

Test Plan:
- DIV_LAT=2; request a=8, b=2, op=QUO, tag=3 with rsp_ready=1 -> rsp_data=4, tag=3, dz=ovf=0, rsp_valid asserted 3 cycles after acceptance.
- a=9, b=2, op=REM, then a=-78443, b=799, op=QUO, then the same operands with op=REM, issued back to back -> responses in order: 1, -98, -141.
- a=5, b=0: op=QUO -> rsp_data=0xFFFF_FFFF_FFFF_FFFF with dz=1; op=REM -> rsp_data=5 with dz=1. Both respond 1 cycle after acceptance.
- a=0x8000_0000_0000_0000, b=-1: op=QUO -> rsp_data=0x8000_0000_0000_0000 with ovf=1; op=REM -> rsp_data=0 with ovf=1.
- Hold rsp_ready=0 and push requests until req_ready=0 -> DEPTH accepted while the sequencer holds the first result in DONE. Then raise rsp_ready -> all responses drain in order with tags intact, and req_ready returns to 1.
- Assert rst_n=0 while in WAIT with 2 entries queued -> rsp_valid=0 and req_ready=1 immediately. After release, no stale responses appear, and a new request a=-534224, b=-9799, op=QUO returns 54.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared encodings and constants for the divide sequencer
package div_sequencer_pkg;

    localparam logic OP_QUO = 1'b0;
    localparam logic OP_REM = 1'b1;

    localparam logic [63:0] INT64_MIN  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL_ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// rtl/div_sequencer_if.sv - request, divider and response signals of the divide sequencer
// slave  : sequencer side (accepts requests, drives divider operands, returns responses)
// master : environment side (issues requests, supplies divider results, consumes responses)
interface div_sequencer_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_op;
    logic [63:0]      req_a;
    logic [63:0]      req_b;
    logic [TAG_W-1:0] req_tag;

    logic [63:0]      div_a;
    logic [63:0]      div_b;
    logic [63:0]      div_quo;
    logic [63:0]      div_r;
    logic             div_ovf;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [63:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_dz;
    logic             rsp_ovf;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag,
        input  div_quo, div_r, div_ovf,
        input  rsp_ready,
        output req_ready,
        output div_a, div_b,
        output rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag,
        output div_quo, div_r, div_ovf,
        output rsp_ready,
        input  req_ready,
        input  div_a, div_b,
        input  rsp_valid, rsp_data, rsp_tag, rsp_dz, rsp_ovf
    );

endinterface

// File: rtl/div_req_fifo.sv
// rtl/div_req_fifo.sv - DEPTH x W show-ahead request FIFO with wrap-bit pointers
// clk, rst_n        : clock, asynchronous active-low reset
// push_i, wdata_i   : write strobe (ignored when full) and entry
// pop_i             : read strobe (ignored when empty)
// rdata_o           : head entry, valid while !empty_o
// full_o, empty_o   : status derived from registered pointers only
module div_req_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 133
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push, do_pop;

    // Full blocks a push even when a pop happens in the same cycle.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - issue/response sequencer in front of a multicycle 64-bit signed divider
// clk, rst_n : clock, asynchronous active-low reset
// bus        : request (req_*), divider operand/result (div_*) and response (rsp_*) signals
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int DIV_LAT = 2,
    parameter int TAG_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    div_sequencer_if.slave  bus
);
    localparam int W     = 1 + 64 + 64 + TAG_W;
    localparam int CNT_W = $clog2(DIV_LAT) + 1;

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      div_a_q, div_a_d, div_b_q, div_b_d;
    logic             op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [63:0]      data_q, data_d;
    logic             dz_q, dz_d, ovf_q, ovf_d;

    logic             fifo_full, fifo_empty, pop, issue;
    logic [W-1:0]     head;
    logic             h_op;
    logic [63:0]      h_a, h_b;
    logic [TAG_W-1:0] h_tag;

    // The divider's own overflow flag is deliberately ignored; specials are decoded here.
    logic unused_div_ovf;
    assign unused_div_ovf = bus.div_ovf;

    div_req_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (bus.req_valid),
        .wdata_i ({bus.req_op, bus.req_a, bus.req_b, bus.req_tag}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {h_op, h_a, h_b, h_tag} = head;

    assign bus.req_ready = !fifo_full;
    assign bus.div_a     = div_a_q;
    assign bus.div_b     = div_b_q;
    assign bus.rsp_valid = (state_q == DONE);
    assign bus.rsp_data  = data_q;
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_dz    = dz_q;
    assign bus.rsp_ovf   = ovf_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_a_d = div_a_q;
        div_b_d = div_b_q;
        op_d    = op_q;
        tag_d   = tag_q;
        data_d  = data_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        issue   = 1'b0;
        pop     = 1'b0;

        case (state_q)
            IDLE: issue = !fifo_empty;
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    data_d  = (op_q == OP_REM) ? bus.div_r : bus.div_quo;
                    dz_d    = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    // Back-to-back issue straight out of the handshake edge.
                    if (!fifo_empty) issue   = 1'b1;
                    else             state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            pop     = 1'b1;
            div_a_d = h_a;
            div_b_d = h_b;
            op_d    = h_op;
            tag_d   = h_tag;
            if (h_b == '0) begin
                data_d  = (h_op == OP_REM) ? h_a : ALL_ONES64;
                dz_d    = 1'b1;
                ovf_d   = 1'b0;
                state_d = DONE;
            end else if (h_a == INT64_MIN && h_b == ALL_ONES64) begin
                data_d  = (h_op == OP_REM) ? 64'd0 : INT64_MIN;
                dz_d    = 1'b0;
                ovf_d   = 1'b1;
                state_d = DONE;
            end else begin
                cnt_d   = CNT_W'(DIV_LAT - 1);
                state_d = WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_a_q <= '0;
            div_b_q <= '0;
            op_q    <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_a_q <= div_a_d;
            div_b_q <= div_b_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule
